// File: rtl/csi2_rx_glue.sv
// ============================================================================
// Module   : csi2_rx_glue
// Purpose  : CSI-2 RX packet-parser to byte-to-pixel glue; frame/line tracking,
//            DT/VC filtering, word-count enforcement, error and line statistics.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csi2_rx_glue #(
    parameter logic [5:0] DT         = 6'h2A,
    parameter logic [1:0] VC         = 2'b00,
    parameter int         LINE_CNT_W = 12
) (
    input  logic                  reset_byte_n_i,
    input  logic                  byte_clk_i,
    input  logic                  rx_sp_en_i,
    input  logic                  rx_lp_en_i,
    input  logic [5:0]            rx_dt_i,
    input  logic [1:0]            rx_vc_i,
    input  logic [15:0]           rx_wc_i,
    input  logic                  rx_payload_en_i,
    input  logic [63:0]           rx_payload_i,
    output logic                  b2p_fv_o,
    output logic                  b2p_lv_o,
    output logic                  b2p_byte_en_o,
    output logic [63:0]           b2p_byte_data_o,
    output logic [7:0]            b2p_byte_keep_o,
    output logic                  b2p_line_end_o,
    output logic [15:0]           frame_cnt_o,
    output logic [LINE_CNT_W-1:0] line_cnt_o,
    output logic [LINE_CNT_W-1:0] lines_last_frame_o,
    output logic                  err_proto_o,
    output logic                  err_wc_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_LINE  = 2'd2,
        ST_DROP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  base_q, base_d;     // DROP returns to FRAME when set, IDLE otherwise
    logic [15:0]           rem_q, rem_d;
    logic                  fv_q, fv_d;
    logic                  lv_q, lv_d;
    logic                  en_q, en_d;
    logic [63:0]           data_q, data_d;
    logic [7:0]            keep_q, keep_d;
    logic                  le_q, le_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic [LINE_CNT_W-1:0] llf_q, llf_d;
    logic                  errp_q, errp_d;
    logic                  errw_q, errw_d;

    logic                  hdr_any, hdr_both, vc_ok, is_fs, is_fe, is_acc;
    logic [7:0]            keep_w;
    logic [15:0]           rem_dec;
    logic [LINE_CNT_W-1:0] lc;
    state_t                ctx;
    logic                  last_beat;

    assign hdr_any  = rx_sp_en_i | rx_lp_en_i;
    assign hdr_both = rx_sp_en_i & rx_lp_en_i;
    assign vc_ok    = (rx_vc_i == VC);
    assign is_fs    = rx_sp_en_i & vc_ok & (rx_dt_i == 6'h00);
    assign is_fe    = rx_sp_en_i & vc_ok & (rx_dt_i == 6'h01);
    assign is_acc   = rx_lp_en_i & vc_ok & (rx_dt_i == DT);
    assign keep_w   = (rem_q >= 16'd8) ? 8'hFF : ~(8'hFF << rem_q[2:0]);
    assign rem_dec  = (rem_q >= 16'd8) ? (rem_q - 16'd8) : 16'd0;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        rem_d       = rem_q;
        fv_d        = fv_q;
        en_d        = 1'b0;
        data_d      = '0;
        keep_d      = '0;
        le_d        = 1'b0;
        errp_d      = 1'b0;
        errw_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        llf_d       = llf_q;
        lc          = line_cnt_q;
        ctx         = state_q;
        last_beat   = 1'b0;

        if (hdr_both) begin
            errp_d = 1'b1;
        end else begin
            if (state_q == ST_LINE || state_q == ST_DROP) begin
                if (hdr_any) begin
                    // Truncated packet: close it out, then let the header act from the outer state
                    errw_d = 1'b1;
                    rem_d  = '0;
                    if (state_q == ST_LINE) begin
                        le_d = 1'b1;
                        lc   = lc + LINE_CNT_W'(1);
                        ctx  = ST_FRAME;
                    end else begin
                        ctx = base_q ? ST_FRAME : ST_IDLE;
                    end
                end else if (rx_payload_en_i) begin
                    rem_d = rem_dec;
                    if (state_q == ST_LINE) begin
                        en_d   = 1'b1;
                        data_d = rx_payload_i;
                        keep_d = keep_w;
                    end
                    if (rem_dec == 16'd0) begin
                        if (state_q == ST_LINE) begin
                            le_d      = 1'b1;
                            last_beat = 1'b1;
                            lc        = lc + LINE_CNT_W'(1);
                            state_d   = ST_FRAME;
                        end else begin
                            state_d = base_q ? ST_FRAME : ST_IDLE;
                        end
                    end
                end
            end

            if (ctx == ST_IDLE || ctx == ST_FRAME) begin
                if (hdr_any) begin
                    state_d = ctx;
                end
                if (ctx == ST_IDLE) begin
                    if (is_fs) begin
                        state_d = ST_FRAME;
                        fv_d    = 1'b1;
                        lc      = '0;
                    end else if (is_fe) begin
                        errp_d = 1'b1;
                    end else if (rx_lp_en_i) begin
                        errp_d = is_acc;
                        rem_d  = rx_wc_i;
                        base_d = 1'b0;
                        if (rx_wc_i != 16'd0) begin
                            state_d = ST_DROP;
                        end
                    end
                end else begin
                    if (is_fe) begin
                        state_d     = ST_IDLE;
                        fv_d        = 1'b0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        llf_d       = lc;
                    end else if (is_fs) begin
                        errp_d = 1'b1;
                        lc     = '0;
                    end else if (is_acc) begin
                        if (rx_wc_i != 16'd0) begin
                            state_d = ST_LINE;
                            rem_d   = rx_wc_i;
                        end else begin
                            errw_d = 1'b1;
                        end
                    end else if (rx_lp_en_i) begin
                        rem_d  = rx_wc_i;
                        base_d = 1'b1;
                        if (rx_wc_i != 16'd0) begin
                            state_d = ST_DROP;
                        end
                    end
                end
                if (!hdr_any && rx_payload_en_i) begin
                    errw_d = 1'b1;
                end
            end
        end

        // lv stays up through the final beat of a line and drops the cycle after
        lv_d       = (state_d == ST_LINE) || last_beat;
        line_cnt_d = lc;
    end

    always_ff @(posedge byte_clk_i or negedge reset_byte_n_i) begin
        if (!reset_byte_n_i) begin
            state_q     <= ST_IDLE;
            base_q      <= 1'b0;
            rem_q       <= '0;
            fv_q        <= 1'b0;
            lv_q        <= 1'b0;
            en_q        <= 1'b0;
            data_q      <= '0;
            keep_q      <= '0;
            le_q        <= 1'b0;
            frame_cnt_q <= '0;
            line_cnt_q  <= '0;
            llf_q       <= '0;
            errp_q      <= 1'b0;
            errw_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            rem_q       <= rem_d;
            fv_q        <= fv_d;
            lv_q        <= lv_d;
            en_q        <= en_d;
            data_q      <= data_d;
            keep_q      <= keep_d;
            le_q        <= le_d;
            frame_cnt_q <= frame_cnt_d;
            line_cnt_q  <= line_cnt_d;
            llf_q       <= llf_d;
            errp_q      <= errp_d;
            errw_q      <= errw_d;
        end
    end

    assign b2p_fv_o           = fv_q;
    assign b2p_lv_o           = lv_q;
    assign b2p_byte_en_o      = en_q;
    assign b2p_byte_data_o    = data_q;
    assign b2p_byte_keep_o    = keep_q;
    assign b2p_line_end_o     = le_q;
    assign frame_cnt_o        = frame_cnt_q;
    assign line_cnt_o         = line_cnt_q;
    assign lines_last_frame_o = llf_q;
    assign err_proto_o        = errp_q;
    assign err_wc_o           = errw_q;

endmodule

`default_nettype wire

// File: tb/tb_csi2_rx_glue.sv
// ============================================================================
// Module   : tb_csi2_rx_glue
// Purpose  : Scoreboard bench for csi2_rx_glue with directed packet sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_csi2_rx_glue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sp_en = 1'b0, lp_en = 1'b0, pay_en = 1'b0;
    logic [5:0]  dt = '0;
    logic [1:0]  vc = '0;
    logic [15:0] wc = '0;
    logic [63:0] pay = '0;

    logic        fv, lv, en, le, ep, ew;
    logic [63:0] data;
    logic [7:0]  keep;
    logic [15:0] frame_cnt;
    logic [11:0] line_cnt, llf;

    always #5 clk = ~clk;

    csi2_rx_glue #(.DT(6'h2A), .VC(2'b00), .LINE_CNT_W(12)) dut (
        .reset_byte_n_i    (rst_n),
        .byte_clk_i        (clk),
        .rx_sp_en_i        (sp_en),
        .rx_lp_en_i        (lp_en),
        .rx_dt_i           (dt),
        .rx_vc_i           (vc),
        .rx_wc_i           (wc),
        .rx_payload_en_i   (pay_en),
        .rx_payload_i      (pay),
        .b2p_fv_o          (fv),
        .b2p_lv_o          (lv),
        .b2p_byte_en_o     (en),
        .b2p_byte_data_o   (data),
        .b2p_byte_keep_o   (keep),
        .b2p_line_end_o    (le),
        .frame_cnt_o       (frame_cnt),
        .line_cnt_o        (line_cnt),
        .lines_last_frame_o(llf),
        .err_proto_o       (ep),
        .err_wc_o          (ew)
    );

    typedef struct packed {
        logic        en;
        logic [63:0] data;
        logic [7:0]  keep;
        logic        le;
        logic        ep;
        logic        ew;
        logic        lv;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // Monitor: every cycle the DUT shows an event, pop the oldest expectation
    always @(negedge clk) begin
        if (rst_n && (en || le || ep || ew)) begin
            ev_t act;
            ev_t e;
            act = {en, data, keep, le, ep, ew, lv};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL event: unexpected output en=%0b data=%h keep=%h le=%0b ep=%0b ew=%0b lv=%0b",
                         en, data, keep, le, ep, ew, lv);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    n_bad++;
                    $display("FAIL event @%0t: got en=%0b data=%h keep=%h le=%0b ep=%0b ew=%0b lv=%0b, want en=%0b data=%h keep=%h le=%0b ep=%0b ew=%0b lv=%0b",
                             $time, act.en, act.data, act.keep, act.le, act.ep, act.ew, act.lv,
                             e.en, e.data, e.keep, e.le, e.ep, e.ew, e.lv);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic push(input logic e_en, input logic [63:0] d, input logic [7:0] k,
                        input logic e_le, input logic e_ep, input logic e_ew, input logic e_lv);
        ev_t e;
        e = {e_en, d, k, e_le, e_ep, e_ew, e_lv};
        exp_q.push_back(e);
    endtask

    task automatic drv(input logic s, input logic l, input logic [5:0] t, input logic [1:0] v,
                       input logic [15:0] w, input logic p, input logic [63:0] d);
        @(negedge clk);
        sp_en = s; lp_en = l; dt = t; vc = v; wc = w; pay_en = p; pay = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, 0, 6'h00, 2'b00, 16'd0, 0, 64'd0);
    endtask

    task automatic fs();                   drv(1, 0, 6'h00, 2'b00, 16'd0, 0, 64'd0); endtask
    task automatic fe();                   drv(1, 0, 6'h01, 2'b00, 16'd0, 0, 64'd0); endtask
    task automatic lp(input logic [5:0] t, input logic [1:0] v, input logic [15:0] w);
        drv(0, 1, t, v, w, 0, 64'd0);
    endtask
    task automatic beat(input logic [63:0] d); drv(0, 0, 6'h00, 2'b00, 16'd0, 1, d); endtask
    task automatic beat_exp(input logic [63:0] d, input logic [7:0] k, input logic last);
        push(1, d, k, last, 0, 0, 1);
        beat(d);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_flags", {56'd0, fv, lv, en, le, ep, ew}, 64'd0);
        chk("reset_data_keep", data | {56'd0, keep}, 64'd0);
        chk("reset_counters", {24'd0, frame_cnt, line_cnt, llf}, 64'd0);

        // Single line, wc=20: partial last beat
        fs();
        lp(6'h2A, 2'b00, 16'd20);
        chk("t1_fv_after_fs", {63'd0, fv}, 64'd1);
        beat_exp(64'h1111_0000_0000_0001, 8'hFF, 0);
        beat_exp(64'h1111_0000_0000_0002, 8'hFF, 0);
        beat_exp(64'h1111_0000_0000_0003, 8'h0F, 1);
        fe();
        idle(1);
        chk("t1_fv_after_fe", {63'd0, fv}, 64'd0);
        chk("t1_frame_cnt", {48'd0, frame_cnt}, 64'd1);
        chk("t1_lines_last", {52'd0, llf}, 64'd1);

        // Two full lines of 16 bytes
        fs();
        lp(6'h2A, 2'b00, 16'd16);
        beat_exp(64'h2222_0000_0000_0001, 8'hFF, 0);
        beat_exp(64'h2222_0000_0000_0002, 8'hFF, 1);
        lp(6'h2A, 2'b00, 16'd16);
        chk("t2_line_cnt_1", {52'd0, line_cnt}, 64'd1);
        beat_exp(64'h2222_0000_0000_0003, 8'hFF, 0);
        beat_exp(64'h2222_0000_0000_0004, 8'hFF, 1);
        fe();
        chk("t2_line_cnt_2", {52'd0, line_cnt}, 64'd2);
        idle(1);
        chk("t2_lines_last", {52'd0, llf}, 64'd2);
        chk("t2_frame_cnt", {48'd0, frame_cnt}, 64'd2);

        // Wrong VC is dropped silently, then a matching 8-byte line
        fs();
        lp(6'h2A, 2'b01, 16'd24);
        beat(64'h3333_0000_0000_0001);
        beat(64'h3333_0000_0000_0002);
        beat(64'h3333_0000_0000_0003);
        lp(6'h2A, 2'b00, 16'd8);
        beat_exp(64'h3333_0000_0000_0004, 8'hFF, 1);
        fe();
        idle(1);
        chk("t3_frame_cnt", {48'd0, frame_cnt}, 64'd3);
        chk("t3_lines_last", {52'd0, llf}, 64'd1);

        // Truncated line closed by FE
        fs();
        lp(6'h2A, 2'b00, 16'd32);
        beat_exp(64'h4444_0000_0000_0001, 8'hFF, 0);
        beat_exp(64'h4444_0000_0000_0002, 8'hFF, 0);
        push(0, 64'd0, 8'h00, 1, 0, 1, 0);
        fe();
        idle(1);
        chk("t4_line_cnt", {52'd0, line_cnt}, 64'd1);
        chk("t4_fv", {63'd0, fv}, 64'd0);
        chk("t4_lines_last", {52'd0, llf}, 64'd1);
        chk("t4_frame_cnt", {48'd0, frame_cnt}, 64'd4);

        // Protocol errors, wc=0 line, excess payload beat
        push(0, 64'd0, 8'h00, 0, 1, 0, 0);
        fe();
        fs();
        lp(6'h2A, 2'b00, 16'd8);
        beat_exp(64'h5555_0000_0000_0001, 8'hFF, 1);
        push(0, 64'd0, 8'h00, 0, 1, 0, 0);
        fs();
        chk("t5_line_cnt_before_fs", {52'd0, line_cnt}, 64'd1);
        idle(1);
        chk("t5_line_cnt_after_fs", {52'd0, line_cnt}, 64'd0);
        push(0, 64'd0, 8'h00, 0, 1, 0, 0);
        drv(1, 1, 6'h00, 2'b00, 16'd8, 0, 64'd0);
        push(0, 64'd0, 8'h00, 0, 0, 1, 0);
        lp(6'h2A, 2'b00, 16'd0);
        lp(6'h2A, 2'b00, 16'd8);
        beat_exp(64'h5555_0000_0000_0002, 8'hFF, 1);
        push(0, 64'd0, 8'h00, 0, 0, 1, 0);
        beat(64'h5555_0000_0000_0003);
        idle(1);
        chk("t5_line_cnt_end", {52'd0, line_cnt}, 64'd1);
        fe();
        idle(1);
        chk("t5_frame_cnt", {48'd0, frame_cnt}, 64'd5);

        // Reset in the middle of a 40-byte line
        fs();
        lp(6'h2A, 2'b00, 16'd40);
        beat_exp(64'h6666_0000_0000_0001, 8'hFF, 0);
        idle(1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_flags", {56'd0, fv, lv, en, le, ep, ew}, 64'd0);
        chk("t6_rst_counters", {24'd0, frame_cnt, line_cnt, llf}, 64'd0);
        beat(64'h6666_0000_0000_0002);
        beat(64'h6666_0000_0000_0003);
        idle(1);
        chk("t6_rst_held_data", data | {56'd0, keep}, 64'd0);
        rst_n = 1'b1;
        idle(2);
        chk("t6_post_rst_fv", {63'd0, fv}, 64'd0);
        fs();
        lp(6'h2A, 2'b00, 16'd8);
        beat_exp(64'h6666_0000_0000_0004, 8'hFF, 1);
        idle(1);
        chk("t6_fv_restart", {63'd0, fv}, 64'd1);
        chk("t6_line_cnt_restart", {52'd0, line_cnt}, 64'd1);

        idle(4);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/csi2_rx_glue.md
Name: csi2_rx_glue

Overview:
- Glue logic between the CSI-2 RX DPHY/packet-parser byte interface and the byte-to-pixel converter on the receive side.
- Tracks frame state from Frame Start and Frame End short packets.
- Accepts long packets that match the configured DT/VC, and forwards their payload with per-beat byte-keep masks.
- Enforces word-count boundaries, silently drops non-matching packets, and reports protocol and word-count errors plus frame/line statistics.

Parameters:
- DT, 6'h2A, active video data type accepted for forwarding.
- VC, 2'b00, virtual channel accepted.
- LINE_CNT_W, 12, width of the line counters.

Ports:
- reset_byte_n_i  in  1  reset, asynchronous, active-low.
- byte_clk_i  in  1  clock, byte clock.
- rx_sp_en_i  in  1  short packet header valid, 1-cycle pulse.
- rx_lp_en_i  in  1  long packet header valid, 1-cycle pulse.
- rx_dt_i  in  6  header data type, valid with sp_en/lp_en.
- rx_vc_i  in  2  header virtual channel.
- rx_wc_i  in  16  long packet word count in bytes.
- rx_payload_en_i  in  1  payload beat valid.
- rx_payload_i  in  64  payload, 8 bytes/beat, byte0 = [7:0].
- b2p_fv_o  out  1  frame valid level.
- b2p_lv_o  out  1  line valid level.
- b2p_byte_en_o  out  1  forwarded payload beat valid.
- b2p_byte_data_o  out  64  forwarded payload.
- b2p_byte_keep_o  out  8  valid-byte mask for the beat.
- b2p_line_end_o  out  1  pulse with the last beat of a line.
- frame_cnt_o  out  16  completed frames, wraps.
- line_cnt_o  out  LINE_CNT_W  lines completed in current frame, wraps.
- lines_last_frame_o  out  LINE_CNT_W  line count latched at Frame End.
- err_proto_o  out  1  1-cycle pulse, protocol error.
- err_wc_o  out  1  1-cycle pulse, word-count error.

Behaviour:
- Reset: every output is 0; FSM is IDLE; remaining-byte counter is 0. Reset is honoured mid-line: lv/fv drop immediately and nothing further is forwarded.
- All outputs are registered. Latency is 1 cycle from the input event to the output.
- Header match: a header "matches" when rx_vc_i==VC. A long packet is accepted only if it matches and rx_dt_i==DT.
- Short packets: FS = DT 6'h00, FE = DT 6'h01. Other short DTs (e.g. 0x02/0x03) and non-matching VC are ignored.
- rx_sp_en_i and rx_lp_en_i high in the same cycle: err_proto pulse; both headers are ignored and the state is unchanged.
- FSM states: IDLE, FRAME, LINE, DROP.
- IDLE:
  - FS -> FRAME; fv=1; line_cnt=0.
  - FE -> err_proto; stay in IDLE.
  - Any lp_en -> DROP with rem=wc (wc 0 returns straight to IDLE); matched-DT lp_en also pulses err_proto.
- FRAME:
  - FE -> IDLE; fv=0; frame_cnt+1; lines_last_frame=line_cnt.
  - FS -> err_proto; line_cnt=0; stay in FRAME.
  - Accepted lp_en with wc>0 -> LINE; rem=wc; lv=1.
  - Accepted lp_en with wc=0 -> err_wc; stay in FRAME.
  - Non-accepted lp_en -> DROP with rem=wc.
- LINE, per payload beat:
  - byte_en=1, data forwarded.
  - keep=8'hFF if rem>=8, else (1<<rem)-1.
  - rem -= min(8,rem).
  - When rem reaches 0: line_end=1 on that beat, lv=0, line_cnt+1 -> FRAME.
- DROP: payload beats decrement rem with no output. rem reaching 0 -> return to the prior state (FRAME or IDLE).
- Header arriving in LINE or DROP (truncated packet):
  - err_wc pulse.
  - If in LINE: lv=0, line_end pulse with no data, line_cnt+1.
  - The new header is then processed that same cycle as if in FRAME (or IDLE when the drop originated in IDLE).
- Stray payload_en in IDLE/FRAME without a coincident header (excess bytes) -> err_wc pulse; data is discarded.
- payload_en coincident with lp_en in IDLE/FRAME is ignored silently.
- Gaps in payload_en within LINE/DROP are allowed.
- Counters wrap with no error.

Test Plan:
- FS; lp_en DT=2A wc=20; 3 beats; FE -> keep FF,FF,0F; line_end on beat 3; lv high for beats 1-3; fv low after FE; frame_cnt=1.
- FS; 2 lines wc=16; FE -> line_cnt 1 then 2; lines_last_frame=2; each line has 2 beats with keep FF; no errors.
- FS; lp_en VC=1 wc=24 plus 3 beats; then matched line wc=8 -> first packet produces no output and no error; second forwards 1 beat, keep FF.
- FS; lp_en wc=32; 2 beats; then FE -> err_wc pulse; line_end pulse with byte_en=0; line_cnt=1; fv=0; lines_last_frame=1.
- FE in IDLE; FS then FS; sp_en+lp_en together; wc=8 line followed by an extra beat -> err_proto pulses ×3; err_wc on the extra beat; line_cnt reset by the second FS.
- Assert reset mid-LINE at beat 2 of wc=40 -> all outputs 0 next edge; later beats not forwarded; a fresh FS after release starts normally.
